// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a registered read port.
// Each access takes IDLE -> ACCESS -> RESP; all outputs are registered.
module ram_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_0,
    input  logic        i_req_1,
    input  logic        i_we_0,
    input  logic        i_we_1,
    input  logic [15:0] i_addr_0,
    input  logic [15:0] i_addr_1,
    input  logic [31:0] i_wdata_0,
    input  logic [31:0] i_wdata_1,
    output logic        o_gnt_0,
    output logic        o_gnt_1,
    output logic        o_done_0,
    output logic        o_done_1,
    output logic [31:0] o_rdata_0,
    output logic [31:0] o_rdata_1,
    output logic [15:0] o_ram_addr,
    output logic [31:0] o_ram_wdata,
    output logic        o_ram_set,
    input  logic [31:0] i_ram_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    logic        rr;
    logic        lat_idx;
    logic        lat_we;

    logic        win_idx;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [31:0] sel_wdata;

    // On a tie the port that was not granted last wins; rr holds the last winner.
    always_comb begin
        win_idx   = (i_req_0 && i_req_1) ? ~rr : i_req_1;
        sel_we    = win_idx ? i_we_1    : i_we_0;
        sel_addr  = win_idx ? i_addr_1  : i_addr_0;
        sel_wdata = win_idx ? i_wdata_1 : i_wdata_0;
    end

    // o_ram_addr / o_ram_wdata double as the latched address and data registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            rr          <= 1'b1;
            lat_idx     <= 1'b0;
            lat_we      <= 1'b0;
            o_gnt_0     <= 1'b0;
            o_gnt_1     <= 1'b0;
            o_done_0    <= 1'b0;
            o_done_1    <= 1'b0;
            o_rdata_0   <= '0;
            o_rdata_1   <= '0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
            o_ram_set   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_gnt_0   <= 1'b0;
            o_gnt_1   <= 1'b0;
            o_done_0  <= 1'b0;
            o_done_1  <= 1'b0;
            o_ram_set <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_0 || i_req_1) begin
                        state       <= ACCESS;
                        o_busy      <= 1'b1;
                        lat_idx     <= win_idx;
                        lat_we      <= sel_we;
                        rr          <= win_idx;
                        o_ram_addr  <= sel_addr;
                        o_ram_wdata <= sel_wdata;
                        o_ram_set   <= sel_we;
                        o_gnt_0     <= ~win_idx;
                        o_gnt_1     <= win_idx;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    if (lat_idx) begin
                        o_done_1 <= 1'b1;
                        if (!lat_we) o_rdata_1 <= i_ram_rdata;
                    end else begin
                        o_done_0 <= 1'b1;
                        if (!lat_we) o_rdata_0 <= i_ram_rdata;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
